// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: reset vector, bubble encoding and fetch FSM states.
// The bubble opcode is also decoded by the IF/ID register.
package mips_pkg;

  localparam logic [31:0] RESET_PC      = 32'h0000_3000;
  localparam logic [5:0]  BUBBLE_OPCODE = 6'b111111;
  localparam logic [31:0] BUBBLE_INSTR  = {BUBBLE_OPCODE, 26'd0};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_buf.sv
// One-entry fetch holding register; load on transfer, clear drops only the valid bit.
// Clear wins over load so a redirect flush cannot be overwritten by a late transfer.
module if_fetch_buf
  import mips_pkg::*;
#(
  parameter logic [31:0] RST_PC4   = 32'h0000_0004,
  parameter logic [31:0] RST_INSTR = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  fetch_entry_t load_dat,
  output logic         valid,
  output fetch_entry_t entry
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      entry <= {RST_PC4, RST_INSTR};
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      entry <= load_dat;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: owns the PC, requests imem, holds one instruction for IF/ID (bubble when empty).
// Zero-latency memory sustains one instruction per cycle; Stall with a full buffer freezes PC and drops imem_req.
// IF_ALIGN_CHECK_EN adds IF_AdEL and a halt state on misaligned redirect targets.
module if_fetch #(
  parameter logic [31:0] RESET_PC     = mips_pkg::RESET_PC,
  parameter logic [31:0] BUBBLE_INSTR = mips_pkg::BUBBLE_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PCPlus4,
  output logic [31:0] INSTR,
  output logic        IF_Valid
`ifdef IF_ALIGN_CHECK_EN
  ,
  output logic        IF_AdEL
`endif
);
  import mips_pkg::*;

  fetch_state_t state, state_nxt;
  logic [31:0]  pc;
  logic [31:0]  pc_plus4;
  logic [31:0]  redirect_target;
  logic         redirect_take;
  logic         xfer;
  logic         buf_valid;
  fetch_entry_t buf_entry;
  fetch_entry_t load_dat;

`ifdef IF_ALIGN_CHECK_EN
  logic misalign;
  assign misalign        = redirect_take && (RedirectPC[1:0] != 2'b00);
  assign redirect_target = misalign ? RedirectPC : {RedirectPC[31:2], 2'b00};
`else
  assign redirect_target = RedirectPC & 32'hFFFF_FFFC;
`endif

  // Once halted only reset can move the PC again.
  assign redirect_take = Redirect && (state != S_HALT);
  assign pc_plus4      = pc + 32'd4;
  assign xfer          = imem_req && imem_rvalid;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = S_RUN;
      S_RUN:   state_nxt = S_RUN;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
`ifdef IF_ALIGN_CHECK_EN
    if (misalign) state_nxt = S_HALT;
`endif
  end

  always_comb begin
    imem_req = (state == S_RUN) && !Redirect && (!buf_valid || !Stall);
  end

  always_ff @(posedge clk) begin
    if (rst)                pc <= RESET_PC;
    else if (redirect_take) pc <= redirect_target;
    else if (xfer)          pc <= pc_plus4;
  end

`ifdef IF_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst)           IF_AdEL <= 1'b0;
    else if (misalign) IF_AdEL <= 1'b1;
  end
`endif

  assign load_dat = '{pc4: pc_plus4, instr: imem_rdata};

  // A consume with a same-edge transfer refills; only a bare consume empties.
  if_fetch_buf #(
    .RST_PC4   (RESET_PC + 32'd4),
    .RST_INSTR (BUBBLE_INSTR)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .load     (xfer),
    .clear    (Redirect || (!Stall && buf_valid && !xfer)),
    .load_dat (load_dat),
    .valid    (buf_valid),
    .entry    (buf_entry)
  );

  assign imem_addr = pc;
  assign PCPlus4   = buf_entry.pc4;
  assign INSTR     = buf_valid ? buf_entry.instr : BUBBLE_INSTR;
  assign IF_Valid  = buf_valid;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: scoreboard of consumed {PCPlus4, INSTR} plus per-cycle port checks.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        Stall;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] PCPlus4;
  logic [31:0] INSTR;
  logic        IF_Valid;
`ifdef IF_ALIGN_CHECK_EN
  logic        IF_AdEL;
`endif

  int          checks   = 0;
  int          failures = 0;
  int          lat      = 0;
  int          wait_cnt = 0;
  logic        force_rv = 1'b0;
  logic [63:0] sb_q[$];
  logic [63:0] sb_exp;

  always #5 clk = ~clk;

  if_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .Stall       (Stall),
    .Redirect    (Redirect),
    .RedirectPC  (RedirectPC),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .PCPlus4     (PCPlus4),
    .INSTR       (INSTR),
    .IF_Valid    (IF_Valid)
`ifdef IF_ALIGN_CHECK_EN
    ,
    .IF_AdEL     (IF_AdEL)
`endif
  );

  // Memory contents: two fixed words at the reset vector, a recognisable pattern elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_3000) return 32'h2408_0001;
    if (a == 32'h0000_3004) return 32'h2409_0002;
    return a ^ 32'hA5A5_0000;
  endfunction

  assign imem_rvalid = force_rv | (imem_req && (wait_cnt >= lat));
  assign imem_rdata  = force_rv ? 32'hDEAD_BEEF : mem_word(imem_addr);

  always @(posedge clk) begin
    if (rst || !imem_req || imem_rvalid) wait_cnt <= 0;
    else                                 wait_cnt <= wait_cnt + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // IF/ID takes the buffer on any non-stalled, non-redirect cycle.
  always @(negedge clk) begin
    if (!rst && IF_Valid && !Stall && !Redirect) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got pc4=%h instr=%h expected none", PCPlus4, INSTR);
      end else begin
        sb_exp = sb_q.pop_front();
        chk("sb_consume", {PCPlus4, INSTR}, sb_exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; Stall = 1'b0; Redirect = 1'b0; RedirectPC = 32'h0;
    tick();
    tick();
    @(negedge clk);
    chk("rst_valid",  IF_Valid, 0);
    chk("rst_instr",  INSTR,    32'hFC00_0000);
    chk("rst_pc4",    PCPlus4,  32'h0000_3004);
    chk("rst_req",    imem_req, 0);
    tick();
    rst = 1'b0;

    // zero-latency stream
    sb_q.push_back({32'h0000_3004, 32'h2408_0001});
    sb_q.push_back({32'h0000_3008, 32'h2409_0002});
    @(negedge clk);
    chk("idle_req",   imem_req, 0);
    chk("idle_valid", IF_Valid, 0);
    chk("idle_instr", INSTR,    32'hFC00_0000);
    tick();
    @(negedge clk);
    chk("z_req0",  imem_req,  1);
    chk("z_addr0", imem_addr, 32'h0000_3000);
    tick();
    @(negedge clk);
    chk("z_addr1",  imem_addr, 32'h0000_3004);
    chk("z_valid1", IF_Valid,  1);
    chk("z_pc4_1",  PCPlus4,   32'h0000_3004);
    tick();
    @(negedge clk);
    chk("z_valid2", IF_Valid, 1);
    chk("z_pc4_2",  PCPlus4,  32'h0000_3008);
    tick();
    lat = 2;
    do_reset();

    // two-cycle memory latency
    sb_q.push_back({32'h0000_3004, 32'h2408_0001});
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lat_addr",  imem_addr, 32'h0000_3000);
      chk("lat_valid", IF_Valid,  0);
      tick();
    end
    @(negedge clk);
    chk("lat_valid_after", IF_Valid, 1);
    chk("lat_instr",       INSTR,    32'h2408_0001);
    tick();
    lat = 0;
    do_reset();

    // stall with a full buffer
    sb_q.push_back({32'h0000_3004, 32'h2408_0001});
    sb_q.push_back({32'h0000_3008, 32'h2409_0002});
    tick();
    tick();
    Stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_req",   imem_req,  0);
      chk("stall_addr",  imem_addr, 32'h0000_3004);
      chk("stall_instr", INSTR,     32'h2408_0001);
      chk("stall_pc4",   PCPlus4,   32'h0000_3004);
      tick();
    end
    Stall = 1'b0;
    @(negedge clk);
    chk("unstall_req",  imem_req,  1);
    chk("unstall_addr", imem_addr, 32'h0000_3004);
    tick();
    @(negedge clk);
    chk("unstall_valid", IF_Valid, 1);
    tick();

    // redirect while memory presents data
    Redirect = 1'b1; RedirectPC = 32'h0000_4000; force_rv = 1'b1;
    @(negedge clk);
    chk("redir_req", imem_req, 0);
    tick();
    Redirect = 1'b0; force_rv = 1'b0;
    sb_q.push_back({32'h0000_4004, 32'hA5A5_4000});
    @(negedge clk);
    chk("redir_valid", IF_Valid,  0);
    chk("redir_instr", INSTR,     32'hFC00_0000);
    chk("redir_addr",  imem_addr, 32'h0000_4000);
    chk("redir_req2",  imem_req,  1);
    tick();
    @(negedge clk);
    chk("redir_pc4", PCPlus4, 32'h0000_4004);
    tick();

    // redirect together with stall
    Stall = 1'b1; Redirect = 1'b1; RedirectPC = 32'h0000_5000;
    @(negedge clk);
    chk("rs_req", imem_req, 0);
    tick();
    Redirect = 1'b0;
    sb_q.push_back({32'h0000_5004, 32'hA5A5_5000});
    @(negedge clk);
    chk("rs_valid", IF_Valid,  0);
    chk("rs_addr",  imem_addr, 32'h0000_5000);
    tick();
    Stall = 1'b0;
    @(negedge clk);
    chk("rs_pc4", PCPlus4, 32'h0000_5004);
    tick();

    // misaligned redirect target
    Redirect = 1'b1; RedirectPC = 32'h0000_4002;
    tick();
    Redirect = 1'b0; RedirectPC = 32'h0;
`ifdef IF_ALIGN_CHECK_EN
    @(negedge clk);
    chk("ade_flag",  IF_AdEL,   1);
    chk("ade_req",   imem_req,  0);
    chk("ade_valid", IF_Valid,  0);
    chk("ade_addr",  imem_addr, 32'h0000_4002);
    tick();
    @(negedge clk);
    chk("ade_req2", imem_req, 0);
    chk("ade_flag2", IF_AdEL, 1);
    tick();
    do_reset();
    sb_q.push_back({32'h0000_3004, 32'h2408_0001});
    @(negedge clk);
    chk("ade_clear", IF_AdEL, 0);
`else
    @(negedge clk);
    chk("mis_addr", imem_addr, 32'h0000_4000);
    chk("mis_req",  imem_req,  1);
    tick();
    sb_q.push_back({32'h0000_4004, 32'hA5A5_4000});
    @(negedge clk);
    chk("mis_pc4", PCPlus4, 32'h0000_4004);
    tick();
    do_reset();
    sb_q.push_back({32'h0000_3004, 32'h2408_0001});
`endif
    tick();
    @(negedge clk);
    chk("restart_addr", imem_addr, 32'h0000_3000);
    chk("restart_req",  imem_req,  1);
    tick();
    tick();

    // PC wrap at the top of the address space
    Redirect = 1'b1; RedirectPC = 32'hFFFF_FFFC;
    tick();
    Redirect = 1'b0;
    sb_q.push_back({32'h0000_0000, 32'h5A5A_FFFC});
    @(negedge clk);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    @(negedge clk);
    chk("wrap_pc4",   PCPlus4,   32'h0000_0000);
    chk("wrap_addr2", imem_addr, 32'h0000_0000);
    tick();
    Stall = 1'b1;
    @(negedge clk);
    chk("end_req", imem_req, 0);
    tick();

    chk("sb_drain", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
